// File: rtl/riscv_sim_ctrl.sv
// riscv_sim_ctrl: run controller between the bench/FPGA wrapper and riscv_top.
// Sequences core reset, counts run cycles, snoops PC/DMEM, reports PASS/FAIL/TIMEOUT/HALT.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_imem_pc           core fetch PC (snooped)
//   i_dmem_wr_en/addr/byte_sel/wr_data   DMEM write bus (snooped)
//   o_core_rstn         registered active-low reset to the core
//   o_running           high while the run is in progress
//   o_done/o_done_pulse sticky done flag and one-cycle entry pulse
//   o_status            0 NONE, 1 PASS, 2 FAIL, 3 TIMEOUT, 4 HALT
//   o_fail_code         tohost data[XLEN-1:1] on FAIL, else 0
//   o_cycle_cnt         cycles spent running (saturating)

module riscv_sim_ctrl #(
    parameter int               XLEN        = 32,
    parameter int               RST_CYCLES  = 4,
    parameter int               MAX_CYCLES  = 200,
    parameter int               LOOP_CYCLES = 8,
    parameter logic [XLEN-1:0]  TOHOST_ADDR = 'h0000_0FFC,
    parameter int               CNT_W       = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [XLEN-1:0]   i_imem_pc,
    input  logic              i_dmem_wr_en,
    input  logic [XLEN-1:0]   i_dmem_addr,
    input  logic [3:0]        i_dmem_byte_sel,
    input  logic [XLEN-1:0]   i_dmem_wr_data,
    output logic              o_core_rstn,
    output logic              o_running,
    output logic              o_done,
    output logic              o_done_pulse,
    output logic [2:0]        o_status,
    output logic [XLEN-2:0]   o_fail_code,
    output logic [CNT_W-1:0]  o_cycle_cnt
);

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_RUN   = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [2:0] ST_NONE    = 3'd0;
    localparam logic [2:0] ST_PASS    = 3'd1;
    localparam logic [2:0] ST_FAIL    = 3'd2;
    localparam logic [2:0] ST_TIMEOUT = 3'd3;
    localparam logic [2:0] ST_HALT    = 3'd4;

    // Parameters are truncated to the counter width before comparing.
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES) - ONE;
    localparam logic [CNT_W-1:0] MAX_LAST  = CNT_W'(MAX_CYCLES) - ONE;
    localparam logic [CNT_W-1:0] LOOP_LAST = CNT_W'(LOOP_CYCLES) - ONE;

    state_t            state;
    logic [CNT_W-1:0]  rst_cnt;
    logic [CNT_W-1:0]  loop_cnt;
    logic [XLEN-1:0]   pc_prev;
    logic              pc_prev_vld;

    logic              pc_same;
    logic              tohost_hit;
    logic              tohost_pass;
    logic              halt_hit;
    logic              timeout_hit;
    logic              event_hit;
    logic [2:0]        ev_status;

    assign pc_same     = pc_prev_vld && (i_imem_pc == pc_prev);
    assign tohost_hit  = i_dmem_wr_en
                      && (i_dmem_addr == TOHOST_ADDR)
                      && (i_dmem_byte_sel == 4'b1111)
                      && i_dmem_wr_data[0];
    assign tohost_pass = (i_dmem_wr_data == XLEN'(1));
    assign halt_hit    = (LOOP_CYCLES != 0) && pc_same
                      && (loop_cnt == LOOP_LAST);
    assign timeout_hit = (MAX_CYCLES != 0) && (o_cycle_cnt == MAX_LAST);
    assign event_hit   = tohost_hit || halt_hit || timeout_hit;

    // Same-cycle events resolve tohost first, then halt, then timeout.
    always_comb begin
        ev_status = ST_NONE;
        priority case (1'b1)
            tohost_hit:  ev_status = tohost_pass ? ST_PASS : ST_FAIL;
            halt_hit:    ev_status = ST_HALT;
            timeout_hit: ev_status = ST_TIMEOUT;
            default:     ev_status = ST_NONE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= S_RESET;
            rst_cnt      <= '0;
            loop_cnt     <= '0;
            pc_prev      <= '0;
            pc_prev_vld  <= 1'b0;
            o_core_rstn  <= 1'b0;
            o_running    <= 1'b0;
            o_done       <= 1'b0;
            o_done_pulse <= 1'b0;
            o_status     <= ST_NONE;
            o_fail_code  <= '0;
            o_cycle_cnt  <= '0;
        end else begin
            unique case (state)
                S_RESET: begin
                    rst_cnt <= rst_cnt + ONE;
                    if (rst_cnt == RST_LAST) begin
                        state       <= S_RUN;
                        o_core_rstn <= 1'b1;
                        o_running   <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (o_cycle_cnt != '1) begin
                        o_cycle_cnt <= o_cycle_cnt + ONE;
                    end
                    pc_prev     <= i_imem_pc;
                    pc_prev_vld <= 1'b1;
                    if (!pc_same) begin
                        loop_cnt <= '0;
                    end else if (loop_cnt != '1) begin
                        loop_cnt <= loop_cnt + ONE;
                    end
                    if (event_hit) begin
                        state        <= S_DONE;
                        o_running    <= 1'b0;
                        o_done       <= 1'b1;
                        o_done_pulse <= 1'b1;
                        o_status     <= ev_status;
                        o_fail_code  <= tohost_hit ? i_dmem_wr_data[XLEN-1:1]
                                                   : '0;
                    end
                end
                S_DONE: begin
                    // Core keeps running; results stay frozen until i_rst.
                    o_done_pulse <= 1'b0;
                end
                default: begin
                    state <= S_RESET;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_sim_ctrl.sv
// tb_riscv_sim_ctrl: randomized scoreboard bench for riscv_sim_ctrl.
// Stimulus plans a whole run, a reference model predicts its outcome.

module tb_riscv_sim_ctrl;

    localparam int RSTC = 4;
    localparam int MAXC = 200;
    localparam int LOOPC = 8;
    localparam logic [31:0] TOHOST = 32'h0000_0FFC;

    localparam int K_PASS  = 0;
    localparam int K_FAIL  = 1;
    localparam int K_HALT  = 2;
    localparam int K_TMO   = 3;
    localparam int K_PRIO  = 4;
    localparam int K_ABORT = 5;
    localparam int K_RAND  = 6;

    logic        clk = 1'b0;
    logic        i_rst;
    logic [31:0] i_imem_pc;
    logic        i_dmem_wr_en;
    logic [31:0] i_dmem_addr;
    logic [3:0]  i_dmem_byte_sel;
    logic [31:0] i_dmem_wr_data;
    logic        o_core_rstn;
    logic        o_running;
    logic        o_done;
    logic        o_done_pulse;
    logic [2:0]  o_status;
    logic [30:0] o_fail_code;
    logic [31:0] o_cycle_cnt;

    always #5 clk = ~clk;

    riscv_sim_ctrl dut (
        .i_clk           (clk),
        .i_rst           (i_rst),
        .i_imem_pc       (i_imem_pc),
        .i_dmem_wr_en    (i_dmem_wr_en),
        .i_dmem_addr     (i_dmem_addr),
        .i_dmem_byte_sel (i_dmem_byte_sel),
        .i_dmem_wr_data  (i_dmem_wr_data),
        .o_core_rstn     (o_core_rstn),
        .o_running       (o_running),
        .o_done          (o_done),
        .o_done_pulse    (o_done_pulse),
        .o_status        (o_status),
        .o_fail_code     (o_fail_code),
        .o_cycle_cnt     (o_cycle_cnt)
    );

    typedef struct packed {
        logic [2:0]  st;
        logic [30:0] fc;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur_exp;
    bit   cur_vld = 1'b0;
    bit   prev_pulse = 1'b0;
    int   total = 0;
    int   bad = 0;

    logic [31:0] pc_a[256];
    logic        en_a[256];
    logic [31:0] ad_a[256];
    logic [3:0]  bs_a[256];
    logic [31:0] dt_a[256];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, want);
        end
    endtask

    // Monitor: pops the predicted result whenever the DUT signals completion.
    always @(negedge clk) begin
        if (o_done_pulse) begin
            check("pulse_with_done", {31'd0, o_done}, 32'd1);
            check("pulse_one_cycle", {31'd0, prev_pulse}, 32'd0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got status=%0d want none",
                         o_status);
            end else begin
                cur_exp = exp_q.pop_front();
                cur_vld = 1'b1;
                check("status", {29'd0, o_status}, {29'd0, cur_exp.st});
                check("fail_code", {1'b0, o_fail_code}, {1'b0, cur_exp.fc});
                check("cycle_cnt", o_cycle_cnt, cur_exp.cnt);
            end
        end else if (o_done && cur_vld) begin
            check("frozen_status", {29'd0, o_status}, {29'd0, cur_exp.st});
            check("frozen_cnt", o_cycle_cnt, cur_exp.cnt);
            check("frozen_fc", {1'b0, o_fail_code}, {1'b0, cur_exp.fc});
            check("done_not_running", {31'd0, o_running}, 32'd0);
        end
        prev_pulse = o_done_pulse;
    end

    // Reference model: scan the planned run for the first terminating event.
    function automatic exp_t model();
        exp_t r;
        int   eq_run;
        bit   hit;
        r = '0;
        eq_run = 0;
        for (int k = 0; k < 256; k++) begin
            if (k > 0 && pc_a[k] == pc_a[k-1]) eq_run++;
            else eq_run = 0;
            hit = en_a[k] && ad_a[k] == TOHOST && bs_a[k] == 4'hF
               && dt_a[k][0];
            if (hit) begin
                r.st = (dt_a[k] == 32'd1) ? 3'd1 : 3'd2;
                r.fc = (dt_a[k] == 32'd1) ? 31'd0 : dt_a[k][31:1];
                r.cnt = k + 1;
                return r;
            end
            if (eq_run == LOOPC) begin
                r.st = 3'd4;
                r.cnt = k + 1;
                return r;
            end
            if (k == MAXC - 1) begin
                r.st = 3'd3;
                r.cnt = k + 1;
                return r;
            end
        end
        return r;
    endfunction

    task automatic gen(input int kind, input int c, input logic [31:0] data);
        for (int k = 0; k < 256; k++) begin
            pc_a[k] = 32'h1000 + 32'(4 * k);
            en_a[k] = 1'b0;
            ad_a[k] = '0;
            bs_a[k] = '0;
            dt_a[k] = '0;
            if (kind != K_PRIO && $urandom_range(0, 7) == 0) begin
                en_a[k] = 1'b1;
                case ($urandom_range(0, 2))
                    0: begin
                        ad_a[k] = TOHOST;
                        bs_a[k] = 4'($urandom_range(0, 14));
                        dt_a[k] = $urandom | 32'd1;
                    end
                    1: begin
                        ad_a[k] = TOHOST;
                        bs_a[k] = 4'hF;
                        dt_a[k] = $urandom & ~32'd1;
                    end
                    default: begin
                        ad_a[k] = 32'h0000_0FF8;
                        bs_a[k] = 4'hF;
                        dt_a[k] = 32'd1;
                    end
                endcase
            end
            if (kind == K_HALT && k >= c) pc_a[k] = 32'h40;
            if (kind == K_PRIO && k >= MAXC - 1 - LOOPC) pc_a[k] = 32'h40;
            if (kind == K_RAND) begin
                pc_a[k] = 32'h40 + 32'(4 * $urandom_range(0, 1));
                if ($urandom_range(0, 79) == 0) begin
                    en_a[k] = 1'b1;
                    ad_a[k] = TOHOST;
                    bs_a[k] = 4'hF;
                    dt_a[k] = $urandom | 32'd1;
                end
            end
        end
        if (kind == K_PASS || kind == K_FAIL
            || (kind == K_PRIO && data[0])) begin
            en_a[c] = 1'b1;
            ad_a[c] = TOHOST;
            bs_a[c] = 4'hF;
            dt_a[c] = data;
        end
    endtask

    task automatic idle_bus();
        i_dmem_wr_en = 1'b0;
        i_dmem_addr = '0;
        i_dmem_byte_sel = '0;
        i_dmem_wr_data = '0;
    endtask

    task automatic drive(input int k);
        i_imem_pc = pc_a[k];
        i_dmem_wr_en = en_a[k];
        i_dmem_addr = ad_a[k];
        i_dmem_byte_sel = bs_a[k];
        i_dmem_wr_data = dt_a[k];
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        int cnt;
        idle_bus();
        i_rst = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        cur_vld = 1'b0;
        check("rst_core_rstn", {31'd0, o_core_rstn}, 32'd0);
        check("rst_running", {31'd0, o_running}, 32'd0);
        check("rst_done", {30'd0, o_done, o_done_pulse}, 32'd0);
        check("rst_status", {29'd0, o_status}, 32'd0);
        check("rst_fc", {1'b0, o_fail_code}, 32'd0);
        check("rst_cnt", o_cycle_cnt, 32'd0);
        i_rst = 1'b0;
        cnt = 0;
        while (o_core_rstn !== 1'b1 && cnt < 20) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("core_rst_len", cnt, RSTC);
        check("run_start", {31'd0, o_running}, 32'd1);
        check("run_cnt0", o_cycle_cnt, 32'd0);
    endtask

    task automatic run(input int kind, input int c, input logic [31:0] data);
        bit done_seen;
        gen(kind, c, data);
        if (kind != K_ABORT) exp_q.push_back(model());
        do_reset($urandom_range(1, 3));
        if (kind == K_ABORT) begin
            for (int k = 0; k < c; k++) drive(k);
            check("abort_cnt", o_cycle_cnt, 32'(c));
            check("abort_not_done", {31'd0, o_done}, 32'd0);
            return;
        end
        done_seen = 1'b0;
        for (int k = 0; k < 256 && !done_seen; k++) begin
            drive(k);
            if (o_done === 1'b1) done_seen = 1'b1;
        end
        total++;
        if (!done_seen) begin
            bad++;
            $display("FAIL run_timeout: got done=0 want done=1 kind=%0d",
                     kind);
        end
        // Post-completion tohost writes must not disturb the result.
        for (int j = 0; j < 4; j++) begin
            i_imem_pc = 32'h40;
            i_dmem_wr_en = 1'b1;
            i_dmem_addr = TOHOST;
            i_dmem_byte_sel = 4'hF;
            i_dmem_wr_data = (j % 2 == 0) ? 32'h7 : 32'h1;
            @(posedge clk);
            #1;
        end
        idle_bus();
    endtask

    initial begin
        i_rst = 1'b1;
        i_imem_pc = '0;
        idle_bus();
        do_reset(2);
        run(K_PASS, 10, 32'h1);
        run(K_FAIL, 20, 32'h7);
        run(K_HALT, 30, '0);
        run(K_HALT, 0, '0);
        run(K_TMO, 0, '0);
        run(K_PRIO, MAXC - 1, 32'h1);
        run(K_PRIO, MAXC - 1, 32'h0);
        run(K_ABORT, 50, '0);
        run(K_PASS, 5, 32'h1);
        for (int i = 0; i < 14; i++) begin
            int kinds[5];
            kinds = '{K_PASS, K_FAIL, K_HALT, K_TMO, K_RAND};
            run(kinds[$urandom_range(0, 4)], $urandom_range(0, 190),
                $urandom | 32'd1);
        end
        do_reset(1);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/riscv_sim_ctrl.md
Name: riscv_sim_ctrl

Overview:
Synthesizable simulation/run controller placed between the bench (or FPGA wrapper) and riscv_top.
- Sequences the core reset for a parametrised number of cycles.
- Counts run cycles and snoops the IMEM PC and DMEM write bus.
- Terminates a run on one of three events: a tohost-style pass/fail write, a PC self-loop halt, or a cycle timeout.
- Reports a sticky status word and a one-cycle done pulse.

Parameters:
XLEN, 32, data/address width of snooped buses
RST_CYCLES, 4, cycles o_core_rstn is held low after i_rst deasserts (min 1)
MAX_CYCLES, 200, run-cycle timeout; 0 disables timeout
LOOP_CYCLES, 8, consecutive identical-PC cycles that declare halt; 0 disables
TOHOST_ADDR, 32'h0000_0FFC, DMEM byte address of the tohost word
CNT_W, 32, width of the cycle counter

Ports:
i_clk  in  1  clock; all logic rising-edge
i_rst  in  1  synchronous, active-high reset
i_imem_pc  in  XLEN  core PC, same signal as o_riscv_imem_pc
i_dmem_wr_en  in  1  DMEM write enable
i_dmem_addr  in  XLEN  DMEM byte address
i_dmem_byte_sel  in  4  DMEM byte lanes
i_dmem_wr_data  in  XLEN  DMEM write data
o_core_rstn  out  1  active-low reset to riscv_top, registered
o_running  out  1  high while in S_RUN
o_done  out  1  sticky; high in S_DONE
o_done_pulse  out  1  one cycle on entry to S_DONE
o_status  out  3  0 NONE, 1 PASS, 2 FAIL, 3 TIMEOUT, 4 HALT
o_fail_code  out  XLEN-1  tohost data[XLEN-1:1] on FAIL, else 0
o_cycle_cnt  out  CNT_W  cycles spent in S_RUN

Behaviour:
Reset (i_rst=1 at a clock edge, from any state):
- Next cycle: state=S_RESET, rst_cnt=0, o_core_rstn=0.
- o_running, o_done, o_done_pulse = 0; o_status=0, o_fail_code=0, o_cycle_cnt=0.
- Loop counter cleared; pc_prev_vld=0.
- Reset mid-run aborts the run: the core is re-reset and all results are discarded.

S_RESET:
- rst_cnt increments each cycle.
- When rst_cnt==RST_CYCLES-1: next state S_RUN, o_core_rstn=1 and o_running=1 from that edge.
- o_core_rstn is therefore low for exactly RST_CYCLES cycles after the first cycle with i_rst=0.

S_RUN, each cycle:
- o_cycle_cnt increments, saturating at all-ones.
- pc_prev<=i_imem_pc, pc_prev_vld<=1.
- loop_cnt<=(pc_prev_vld && i_imem_pc==pc_prev) ? loop_cnt+1 : 0.

Termination events, evaluated on the current cycle's inputs:
- tohost hit: i_dmem_wr_en && i_dmem_addr==TOHOST_ADDR && i_dmem_byte_sel==4'b1111 && i_dmem_wr_data[0]==1.
  - data==1 -> PASS.
  - any other value -> FAIL, o_fail_code=data[XLEN-1:1].
  - Writes to TOHOST_ADDR with data[0]==0 or partial byte_sel are ignored.
- halt: LOOP_CYCLES!=0 && pc_prev_vld && i_imem_pc==pc_prev && loop_cnt==LOOP_CYCLES-1 -> HALT.
- timeout: MAX_CYCLES!=0 && o_cycle_cnt==MAX_CYCLES-1 -> TIMEOUT.
- Same-cycle priority: tohost > halt > timeout.
- On any event: next state S_DONE, o_status/o_fail_code latched, o_done=1, o_done_pulse=1 for one cycle, o_running=0. The cycle counter includes the event cycle.

S_DONE:
- Terminal until i_rst.
- o_core_rstn stays 1, so the core keeps executing and its state stays observable.
- o_cycle_cnt, o_status and o_fail_code are frozen.
- Further tohost writes, halts and timeouts are ignored.

General:
- All outputs are registered; no combinational input-to-output path.
- Counter compares use CNT_W-wide unsigned arithmetic; parameters are truncated to CNT_W.

Test Plan:
1. RST_CYCLES=4; i_rst high 2 cycles then low -> o_core_rstn low exactly 4 cycles after i_rst falls, then 1; o_running=1 and o_cycle_cnt counts from 0.
2. In run cycle 10: write 32'h1 to 32'h0FFC, byte_sel 4'hF -> next cycle o_status=1, o_done_pulse high for 1 cycle, o_cycle_cnt=11 and frozen. A later write of 32'h7 leaves status unchanged.
3. Write 32'h0000_0007 to tohost -> o_status=2, o_fail_code=3. Separately, byte_sel 4'h1 or data 32'h6 -> ignored, run continues.
4. Hold i_imem_pc=32'h40 constant with LOOP_CYCLES=8 -> o_status=4 after 8 identical-PC comparisons. With LOOP_CYCLES=0 -> run continues to TIMEOUT at o_cycle_cnt=200 (MAX_CYCLES=200), o_status=3.
5. In the same cycle, a pass tohost write, the halt condition and cycle_cnt==MAX_CYCLES-1 -> o_status=1, confirming tohost priority.
6. Assert i_rst for 1 cycle mid-run at cycle 50, and again in S_DONE -> o_core_rstn low next cycle, all status/count outputs 0, a full RST_CYCLES sequence replays, and a new run completes normally.
